// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response port, decoder handshake and redirect.
// master is the fetch queue side; slave is the memory/decoder environment side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             redirect;
    logic [63:0]      redirect_pc;
    logic             imem_req;
    logic [63:0]      imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             instr_valid;
    logic [31:0]      instr;
    logic [63:0]      instr_pc;
    logic             instr_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, occupancy
    );

    modport slave (
        output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential 32-bit fetches with one request in flight,
// buffered with their PCs in a DEPTH-entry FIFO and flushed on a taken-branch redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [63:0]      fetch_pc;
    logic [63:0]      req_pc;
    logic [31:0]      fifo_instr [DEPTH];
    logic [63:0]      fifo_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             space;
    logic             hs;
    logic             push;
    logic             pop;

    always_ff @(posedge clk) begin
        if (reset) state <= S_REQ;
        else       state <= state_nxt;
    end

    // A request is only issued when a slot is free, so a later push can never overflow.
    always_comb begin
        state_nxt       = state;
        space           = occ < OCC_W'(DEPTH);
        bus.imem_req    = !reset && (state == S_REQ) && space && !bus.redirect;
        hs              = bus.imem_req && bus.imem_ready;
        push            = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
        bus.instr_valid = !reset && (occ != '0);
        pop             = bus.instr_valid && bus.instr_ready && !bus.redirect;
        case (state)
            S_REQ: begin
                if (hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid)  state_nxt = S_REQ;
                else if (bus.redirect) state_nxt = S_DISCARD;
            end
            S_DISCARD: begin
                if (bus.imem_rvalid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & ~64'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (hs)   fetch_pc <= fetch_pc + 64'd4;
            if (push) wr_ptr   <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr   <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Datapath storage carries no reset; validity is tracked by occ and state alone.
    always_ff @(posedge clk) begin
        if (hs) req_pc <= fetch_pc;
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.instr     = fifo_instr[rd_ptr];
    assign bus.instr_pc  = fifo_pc[rd_ptr];
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, all checked every
// cycle against a queue-based reference of the fetch stream.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h2000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc      = RESET_PC;
    logic [63:0] m_out_pc  = '0;
    logic [63:0] mem_addr  = '0;
    bit          m_out     = 1'b0;
    bit          m_disc    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Inputs change just after the clock edge and settle before sampling.
    task automatic set_in(input bit rst, input bit rd, input logic [63:0] rpc,
                          input bit rdy, input bit rv, input bit ir);
        reset           = rst;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = mem_word(mem_addr);
        bus.instr_ready = ir;
        #1;
    endtask

    // Check outputs against the reference, take one clock, then advance the reference.
    task automatic tick();
        bit          exp_req = 1'b0;
        bit          rst  = reset;
        bit          rd   = bus.redirect;
        logic [63:0] rpc  = bus.redirect_pc;
        bit          rdy  = bus.imem_ready;
        bit          rv   = bus.imem_rvalid;
        bit          ir   = bus.instr_ready;
        bit          dreq = bus.imem_req;
        logic [63:0] addr = bus.imem_addr;
        if (rst) begin
            chk("req_in_reset", 64'(bus.imem_req), 64'd0);
            chk("valid_in_reset", 64'(bus.instr_valid), 64'd0);
        end else begin
            exp_req = !m_out && (q.size() < DEPTH) && !rd;
            chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
            if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
            chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
            chk("instr_valid", 64'(bus.instr_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("instr", 64'(bus.instr), 64'(q[0].instr));
                chk("instr_pc", bus.instr_pc, q[0].pc);
            end
        end
        @(posedge clk);
        if (dreq && rdy) mem_addr = addr;
        if (rst) begin
            q.delete();
            m_pc   = RESET_PC;
            m_out  = 1'b0;
            m_disc = 1'b0;
        end else if (rd) begin
            q.delete();
            m_pc = rpc & ~64'h3;
            if (m_out) begin
                if (rv) m_out = 1'b0;
                else    m_disc = 1'b1;
            end
        end else begin
            if (q.size() != 0 && ir) void'(q.pop_front());
            if (m_out && rv) begin
                if (!m_disc) q.push_back({mem_word(m_out_pc), m_out_pc});
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (exp_req && rdy) begin
                m_out    = 1'b1;
                m_disc   = 1'b0;
                m_out_pc = m_pc;
                m_pc     = m_pc + 64'd4;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0); tick();
    endtask

    initial begin
        int          first;
        bit          r_rst, r_rd, r_rdy, r_rv, r_ir;
        logic [63:0] r_pc;

        // Sequential fetch with single-cycle memory latency
        reset_dut();
        first = -1;
        for (int c = 0; c < 8; c++) begin
            set_in(0, 0, 0, 1, m_out, 1);
            if (bus.instr_valid && first < 0) first = c;
            if (c == 0) chk("t1_addr0", bus.imem_addr, 64'h2000);
            if (c == 2) chk("t1_addr1", bus.imem_addr, 64'h2004);
            if (c == 2) chk("t1_pc0", bus.instr_pc, 64'h2000);
            if (c == 4) chk("t1_addr2", bus.imem_addr, 64'h2008);
            tick();
        end
        chk("t1_first_valid", 64'(first), 64'd2);

        // Decoder stalled: queue fills, then one pop frees a slot
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            set_in(0, 0, 0, 1, m_out, 0); tick();
        end
        set_in(0, 0, 0, 1, 0, 0);
        chk("t2_occ_full", 64'(bus.occupancy), 64'd4);
        chk("t2_req_low", 64'(bus.imem_req), 64'd0);
        chk("t2_head_pc", bus.instr_pc, 64'h2000);
        tick();
        set_in(0, 0, 0, 1, 0, 1); tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t2_req_after_pop", 64'(bus.imem_req), 64'd1);
        chk("t2_addr_after_pop", bus.imem_addr, 64'h2010);
        tick();

        // Redirect while waiting; stale response arrives two cycles later
        reset_dut();
        set_in(0, 0, 0, 1, 0, 0); tick();
        set_in(0, 0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 1, 0, 0); tick();
        set_in(0, 1, 64'h3003, 1, 0, 0); tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t3_valid_flushed", 64'(bus.instr_valid), 64'd0);
        chk("t3_req_discard", 64'(bus.imem_req), 64'd0);
        tick();
        set_in(0, 0, 0, 1, 1, 0);
        chk("t3_occ_before_stale", 64'(bus.occupancy), 64'd0);
        tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t3_occ_stale_dropped", 64'(bus.occupancy), 64'd0);
        chk("t3_addr_redirect", bus.imem_addr, 64'h3000);
        tick();
        set_in(0, 0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t3_new_pc", bus.instr_pc, 64'h3000);
        tick();

        // Redirect coincident with response and pop
        set_in(0, 1, 64'h3000, 1, 1, 1); tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t4_occ_zero", 64'(bus.occupancy), 64'd0);
        chk("t4_req", 64'(bus.imem_req), 64'd1);
        chk("t4_addr", bus.imem_addr, 64'h3000);
        tick();

        // Memory back-pressure holds the request stable
        reset_dut();
        set_in(0, 0, 0, 1, 0, 1); tick();
        set_in(0, 0, 0, 1, 1, 1); tick();
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 0, 0, 0, 1);
            chk("t5_req_held", 64'(bus.imem_req), 64'd1);
            chk("t5_addr_held", bus.imem_addr, 64'h2004);
            tick();
        end
        set_in(0, 0, 0, 1, 0, 1);
        chk("t5_addr_accept", bus.imem_addr, 64'h2004);
        tick();
        set_in(0, 0, 0, 1, 1, 1); tick();
        set_in(0, 0, 0, 1, 0, 1);
        chk("t5_addr_next", bus.imem_addr, 64'h2008);
        tick();

        // Reset in WAIT with entries queued; late response ignored
        reset_dut();
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, 0, 1, m_out, 0); tick();
        end
        set_in(0, 0, 0, 1, 0, 0);
        chk("t6_occ3", 64'(bus.occupancy), 64'd3);
        tick();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 0);
        chk("t6_occ_reset", 64'(bus.occupancy), 64'd0);
        chk("t6_valid_reset", 64'(bus.instr_valid), 64'd0);
        chk("t6_addr_reset", bus.imem_addr, 64'h2000);
        tick();
        set_in(0, 0, 0, 1, 0, 0);
        chk("t6_occ_late", 64'(bus.occupancy), 64'd0);
        chk("t6_req_late", 64'(bus.imem_req), 64'd1);
        tick();

        // Randomized traffic: back-pressure, stalls, redirects, occasional reset
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom % 300) == 0;
            r_rd  = ($urandom % 16) == 0;
            r_pc  = {$urandom, $urandom};
            r_rdy = ($urandom % 4) != 0;
            r_rv  = m_out && (($urandom % 2) == 1);
            r_ir  = ($urandom % 2) == 1;
            set_in(r_rst, r_rd, r_pc, r_rdy, r_rv, r_ir);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
